// File: rtl/wb_reg_file_pkg.sv
// wb_reg_file_pkg: shared widths and write-back select encodings for the write-back stage.
package wb_reg_file_pkg;
   localparam int DATA_W_DEF   = 8;
   localparam int ADDR_W_DEF   = 3;
   localparam int NUM_REGS     = 2 ** ADDR_W_DEF;
   localparam logic WB_SEL_SHIFT = 1'b1;
   localparam logic WB_SEL_MOVE  = 1'b0;
endpackage

// File: rtl/wb_reg_file_select.sv
// wb_select: 2:1 write-back mux choosing the shifter result or the moved operand.
module wb_select
   import wb_reg_file_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              sel,
   input  logic [DATA_W-1:0] shift_result,
   input  logic [DATA_W-1:0] data1,
   output logic [DATA_W-1:0] wb_data
);
   always_comb wb_data = (sel == WB_SEL_SHIFT) ? shift_result : data1;
endmodule

// File: rtl/wb_reg_file.sv
// wb_reg_file: write-back stage and register file with same-cycle write-through to decode
// and hit flags for the execute-stage forwarding unit.
module wb_reg_file
   import wb_reg_file_pkg::*;
#(
   parameter int DATA_W           = DATA_W_DEF,
   parameter int ADDR_W           = ADDR_W_DEF,
   parameter int RESET_INIT_INDEX = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] EX_WB_Shift_Result,
   input  logic [DATA_W-1:0] EX_WB_Data1,
   input  logic              EX_WB_RegWrite,
   input  logic              EX_WB_SMCtrl,
   input  logic [ADDR_W-1:0] EX_WB_Write_Reg_Num,
   input  logic [ADDR_W-1:0] Read_Reg_Num1,
   input  logic [ADDR_W-1:0] Read_Reg_Num2,
   output logic [DATA_W-1:0] Read_Data1,
   output logic [DATA_W-1:0] Read_Data2,
   output logic [DATA_W-1:0] WB_Data,
   output logic              WB_Fwd_Hit1,
   output logic              WB_Fwd_Hit2
);
   logic [DATA_W-1:0] regs [2**ADDR_W];

   wb_select #(.DATA_W(DATA_W)) u_sel (
      .sel          (EX_WB_SMCtrl),
      .shift_result (EX_WB_Shift_Result),
      .data1        (EX_WB_Data1),
      .wb_data      (WB_Data)
   );

   always_ff @(posedge Clk or negedge Reset)
      if (!Reset)
         for (int k = 0; k < 2**ADDR_W; k++)
            regs[k] <= (RESET_INIT_INDEX != 0) ? DATA_W'(k) : '0;
      else if (EX_WB_RegWrite)
         regs[EX_WB_Write_Reg_Num] <= WB_Data;

   // Gating with Reset keeps the bypass from exposing a write that will never commit.
   always_comb begin
      WB_Fwd_Hit1 = Reset & EX_WB_RegWrite & (EX_WB_Write_Reg_Num == Read_Reg_Num1);
      WB_Fwd_Hit2 = Reset & EX_WB_RegWrite & (EX_WB_Write_Reg_Num == Read_Reg_Num2);
      Read_Data1  = WB_Fwd_Hit1 ? WB_Data : regs[Read_Reg_Num1];
      Read_Data2  = WB_Fwd_Hit2 ? WB_Data : regs[Read_Reg_Num2];
   end
endmodule

// File: tb/tb_wb_reg_file.sv
// tb_wb_reg_file: directed stimulus with a per-cycle model compare plus literal spot checks.
module tb_wb_reg_file;
   logic       Clk = 0, Reset = 0;
   logic [7:0] sh = 0, d1 = 0;
   logic       we = 0, sel = 0;
   logic [2:0] dest = 0, rn1 = 0, rn2 = 0;
   logic [7:0] rd1, rd2, wbd;
   logic       hit1, hit2;
   int         checks = 0, failures = 0;
   bit         started = 0;
   logic [7:0] mdl [8];

   wb_reg_file dut (
      .Clk(Clk), .Reset(Reset), .EX_WB_Shift_Result(sh), .EX_WB_Data1(d1),
      .EX_WB_RegWrite(we), .EX_WB_SMCtrl(sel), .EX_WB_Write_Reg_Num(dest),
      .Read_Reg_Num1(rn1), .Read_Reg_Num2(rn2), .Read_Data1(rd1), .Read_Data2(rd2),
      .WB_Data(wbd), .WB_Fwd_Hit1(hit1), .WB_Fwd_Hit2(hit2)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Architectural state: reset loads register k with k, a committed write stores the selected value.
   initial for (int k = 0; k < 8; k++) mdl[k] = 8'(k);
   always @(negedge Reset) for (int k = 0; k < 8; k++) mdl[k] = 8'(k);
   always @(posedge Clk) if (Reset === 1'b1 && we) mdl[dest] = sel ? sh : d1;

   always @(negedge Clk) if (started) begin
      logic [7:0] w;
      logic       h1, h2;
      w  = sel ? sh : d1;
      h1 = Reset && we && dest == rn1;
      h2 = Reset && we && dest == rn2;
      chk("cyc_wb_data", wbd, w);
      chk("cyc_hit1", {7'b0, hit1}, {7'b0, h1});
      chk("cyc_hit2", {7'b0, hit2}, {7'b0, h2});
      chk("cyc_rd1", rd1, h1 ? w : mdl[rn1]);
      chk("cyc_rd2", rd2, h2 ? w : mdl[rn2]);
   end

   task automatic step();
      @(posedge Clk);
      #2;
   endtask

   initial begin
      repeat (2) step();
      started = 1;
      for (int i = 0; i < 8; i++) begin
         rn1 = 3'(i);
         rn2 = 3'(7 - i);
         #1;
         chk("rst_rd1", rd1, 8'(i));
         chk("rst_rd2", rd2, 8'(7 - i));
         chk("rst_hits", {6'b0, hit1, hit2}, 8'h00);
      end
      step();
      Reset = 1;
      step();
      we = 1; sel = 1; sh = 8'hA5; d1 = 8'h3C; dest = 3; rn1 = 3; rn2 = 0;
      #1;
      chk("byp_shift_rd1", rd1, 8'hA5);
      chk("byp_shift_hit1", {7'b0, hit1}, 8'h01);
      chk("byp_shift_rd2", rd2, 8'h00);
      step();
      we = 0;
      #1;
      chk("arr_shift_rd1", rd1, 8'hA5);
      chk("arr_shift_hit1", {7'b0, hit1}, 8'h00);
      step();
      we = 1; sel = 0; dest = 7; rn1 = 7; rn2 = 7;
      #1;
      chk("move_rd1", rd1, 8'h3C);
      chk("move_rd2", rd2, 8'h3C);
      chk("move_hits", {6'b0, hit1, hit2}, 8'h03);
      rn2 = 6;
      #1;
      chk("move_rd2_other", rd2, 8'h06);
      chk("move_hit2_other", {7'b0, hit2}, 8'h00);
      step();
      we = 0; sel = 1; dest = 2; sh = 8'hFF; rn1 = 2; rn2 = 7;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("nowr_rd1", rd1, 8'h02);
         chk("nowr_hit1", {7'b0, hit1}, 8'h00);
         chk("r7_kept", rd2, 8'h3C);
      end
      we = 1; sel = 1; sh = 8'h55; dest = 5; rn1 = 5;
      step();
      we = 0;
      #1;
      chk("r5_written", rd1, 8'h55);
      we = 1; sh = 8'h99;
      #1;
      chk("r5_bypass", rd1, 8'h99);
      Reset = 0;
      #1;
      chk("midrst_rd1", rd1, 8'h05);
      chk("midrst_hits", {6'b0, hit1, hit2}, 8'h00);
      chk("midrst_r7", rd2, 8'h07);
      chk("midrst_wbd", wbd, 8'h99);
      repeat (2) step();
      chk("rst_nowrite", rd1, 8'h05);
      we = 0;
      Reset = 1;
      #1;
      chk("rel_rd1", rd1, 8'h05);
      we = 1; sel = 1; sh = 8'h11; dest = 1; rn1 = 1; rn2 = 1;
      #1;
      chk("b2b_first", rd1, 8'h11);
      step();
      sh = 8'h22;
      #1;
      chk("b2b_second", rd1, 8'h22);
      step();
      we = 0;
      #1;
      chk("b2b_final", rd1, 8'h22);
      chk("b2b_final2", rd2, 8'h22);
      step();
      started = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout at %0t: got running expected finished", $time);
      $fatal(1);
   end
endmodule

// File: doc/wb_reg_file.md
# wb_reg_file

Write-back stage and architectural register file of the 8-bit pipelined processor. Consumes the EX/WB pipeline register outputs, selects the write-back value (shift result or moved operand) and commits it to one of eight 8-bit registers on the rising clock edge. Provides two combinational read ports to the decode stage, with write-through bypass so that a same-cycle write is visible to decode. Also exports the write-back value and per-port hit flags for the execute-stage forwarding unit.

## Interface
Parameters:
- DATA_W, 8, register and data width
- ADDR_W, 3, register-number width; NUM_REGS = 2**ADDR_W
- RESET_INIT_INDEX, 1, 1: register k resets to k; 0: all registers reset to 0

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low
- EX_WB_Shift_Result  in  DATA_W  shifter result from EX/WB register
- EX_WB_Data1  in  DATA_W  first operand, used for move
- EX_WB_RegWrite  in  1  write enable for this instruction
- EX_WB_SMCtrl  in  1  write-back select: 1 = shift result, 0 = Data1
- EX_WB_Write_Reg_Num  in  ADDR_W  destination register
- Read_Reg_Num1  in  ADDR_W  read port 1 address (decode)
- Read_Reg_Num2  in  ADDR_W  read port 2 address (decode)
- Read_Data1  out  DATA_W  read port 1 data, bypassed
- Read_Data2  out  DATA_W  read port 2 data, bypassed
- WB_Data  out  DATA_W  selected write-back value, combinational
- WB_Fwd_Hit1  out  1  write-back destination matches Read_Reg_Num1 with RegWrite=1
- WB_Fwd_Hit2  out  1  same for port 2

## Operation
- WB_Data = EX_WB_SMCtrl ? EX_WB_Shift_Result : EX_WB_Data1, at full DATA_W width with no extension or truncation.
- Write: on posedge Clk with Reset=1 and EX_WB_RegWrite=1, regs[EX_WB_Write_Reg_Num] <= WB_Data. When RegWrite=0, no register changes.
- All NUM_REGS registers are writable. There is no hardwired zero register.
- Read port n: if WB_Fwd_Hitn then Read_Datan = WB_Data, else regs[Read_Reg_Numn].
- WB_Fwd_Hitn = Reset & EX_WB_RegWrite & (EX_WB_Write_Reg_Num == Read_Reg_Numn).
- Both ports may address the same register. Both then return identical data and identical hit flags.
- Reset asserted: all registers take the init value (k or 0 per RESET_INIT_INDEX) immediately, without waiting for a clock edge. Both hit flags are forced to 0. Read_Datan returns the init value of the addressed register. WB_Data stays combinational from its inputs.
- Reset asserted mid-write: the reset value wins, and no write is committed on any edge while Reset=0.
- Reset released: the first write can occur on the first rising edge at which Reset=1.

## Timing
- Write latency: one edge. Data is present in the array after the posedge and visible through the bypass in the same cycle.
- Read path: purely combinational from Read_Reg_Numn, the array and the EX/WB inputs. No read latency.
- Hit flags and WB_Data: combinational, with no registered outputs.
- There is no handshake or stall input. The stage always accepts and commits the EX/WB contents every cycle.
- Reset values of the outputs: Read_Datan = init(Read_Reg_Numn); WB_Fwd_Hit1 = WB_Fwd_Hit2 = 0; WB_Data follows its inputs, which are 0 when the EX/WB register is itself in reset.

## Structure
- Shared package: DATA_W and ADDR_W defaults, NUM_REGS, and the constants WB_SEL_SHIFT = 1'b1 and WB_SEL_MOVE = 1'b0.
- One sub-module is natural: wb_select, the 2:1 write-back mux driving WB_Data. The array, bypass and hit logic live in wb_reg_file.
- The register array is a single DATA_W × NUM_REGS array, indexed by ADDR_W bits with no range checks beyond width.

## Test plan
- Reset with RESET_INIT_INDEX=1, then sweep Read_Reg_Num1/2 over 0..7 -> Read_Data equals the index (8'h00..8'h07), and both hit flags are 0.
- RegWrite=1, SMCtrl=1, Shift_Result=8'hA5, Data1=8'h3C, dest=3, Read_Reg_Num1=3 -> before the edge Read_Data1=8'hA5 and Hit1=1; after the edge, with RegWrite=0, Read_Data1=8'hA5 from the array.
- RegWrite=1, SMCtrl=0, Data1=8'h3C, dest=7; both read ports at 7 -> Read_Data1=Read_Data2=8'h3C and Hit1=Hit2=1; with port 2 at 6, Read_Data2=8'h06 and Hit2=0.
- RegWrite=0, SMCtrl=1, dest=2, Shift_Result=8'hFF over 3 edges -> reg2 stays 8'h02 and hit flags stay 0.
- Write 8'h55 to reg 5, then assert Reset between edges with RegWrite=1 and dest=5 -> reg5 reads 8'h05 immediately, flags are 0, and no write occurs on edges during reset.
- Back-to-back writes to reg 1 (8'h11 then 8'h22) on consecutive edges with Read_Reg_Num1=1 -> Read_Data1 shows 8'h11, then 8'h22 in the cycle each is in write-back, and the final array value is 8'h22.
